// File: rtl/wait_state_memory_if.sv
// Processor memory bus between the core (master) and the memory responder (slave).
interface wait_state_memory_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        abort;
   logic        write;
   logic        size;
   logic [1:0]  prot;
   logic [1:0]  trans;
   logic        ready;

   modport master (
      output addr, wdata, write, size, prot, trans,
      input  rdata, abort, ready
   );

   modport slave (
      input  addr, wdata, write, size, prot, trans,
      output rdata, abort, ready
   );
endinterface

// File: rtl/wait_state_memory.sv
// Wait-state memory responder: word-addressed storage that stretches N- and S-cycle transfers
// by a programmable number of wait states and aborts out-of-range or unprivileged low writes.
module wait_state_memory #(
   parameter int unsigned ADDR_WORDS = 8192,
   parameter int unsigned N_WAIT     = 2,
   parameter int unsigned S_WAIT     = 0,
   parameter int unsigned PROT_LIMIT = 256
) (
   input logic                clk,
   input logic                reset,
   wait_state_memory_if.slave bus
);

   localparam int unsigned IdxW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic        write_q, size_q, priv_q;
   logic [31:0] rdata_q, rdata_d;
   logic        abort_q, abort_d;

   logic [31:0] mem [ADDR_WORDS];

   logic [3:0]      wait_cnt;
   logic            latch_en;
   logic            cmp_en;
   logic [31:0]     c_addr, c_wdata;
   logic            c_write, c_size, c_priv, c_abort;
   logic [IdxW-1:0] idx;
   logic            mem_we;
   logic [31:0]     mem_wdata;

   // prot[0] (data/opcode) is informational only
   logic unused_prot0;
   assign unused_prot0 = bus.prot[0];

   // Next-state, completion decode and the read/write data path
   always_comb begin
      wait_cnt = (bus.trans == 2'b10) ? 4'(N_WAIT) : 4'(S_WAIT);
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmp_en   = 1'b0;
      latch_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.trans[1]) begin
               if (wait_cnt == 4'd0) begin
                  cmp_en = 1'b1;
               end else begin
                  latch_en = 1'b1;
                  cnt_d    = wait_cnt - 4'd1;
                  state_d  = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               cmp_en  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Completing request: latched copy while waiting, live bus on a zero-wait accept
      if (state_q == StWait) begin
         c_addr  = addr_q;
         c_wdata = wdata_q;
         c_write = write_q;
         c_size  = size_q;
         c_priv  = priv_q;
      end else begin
         c_addr  = bus.addr;
         c_wdata = bus.wdata;
         c_write = bus.write;
         c_size  = bus.size;
         c_priv  = bus.prot[1];
      end

      c_abort = (c_addr >= ADDR_WORDS) || (c_write && !c_priv && (c_addr < PROT_LIMIT));
      idx     = c_addr[IdxW-1:0];

      rdata_d   = rdata_q;
      abort_d   = abort_q;
      mem_we    = 1'b0;
      mem_wdata = c_wdata;
      if (cmp_en) begin
         abort_d = c_abort;
         if (c_abort) begin
            if (!c_write) rdata_d = 32'h0;
         end else if (c_write) begin
            mem_we    = 1'b1;
            mem_wdata = c_size ? c_wdata : {mem[idx][31:8], c_wdata[7:0]};
         end else begin
            rdata_d = c_size ? mem[idx] : {24'h0, mem[idx][7:0]};
         end
      end
   end

   // Control state, request latch and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         write_q <= 1'b0;
         size_q  <= 1'b0;
         priv_q  <= 1'b0;
         rdata_q <= 32'h0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         abort_q <= abort_d;
         if (latch_en) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            write_q <= bus.write;
            size_q  <= bus.size;
            priv_q  <= bus.prot[1];
         end
      end
   end

   // Storage is not reset; reset only suppresses a write in flight
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         mem[idx] <= mem_wdata;
      end
   end

   assign bus.ready = (state_q == StIdle);
   assign bus.rdata = rdata_q;
   assign bus.abort = abort_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench for wait_state_memory: directed steps followed by random traffic,
// checked against a behavioural model of storage, abort rules and wait counts.
module tb_wait_state_memory;

   localparam int unsigned ADDR_WORDS = 8192;
   localparam int unsigned N_W        = 2;
   localparam int unsigned S_W        = 0;
   localparam int unsigned PROT       = 256;

   logic clk = 1'b0;
   logic reset;

   wait_state_memory_if bus ();

   wait_state_memory #(
      .ADDR_WORDS (ADDR_WORDS),
      .N_WAIT     (N_W),
      .S_WAIT     (S_W),
      .PROT_LIMIT (PROT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [31:0] mm [ADDR_WORDS];
   logic [31:0] exp_rdata;
   logic        exp_abort;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Behavioural effect of one completed transfer
   task automatic model_xfer(input logic w, input logic s, input logic priv,
                             input logic [31:0] a, input logic [31:0] d);
      logic ab;
      ab = (a >= ADDR_WORDS) || (w && !priv && (a < PROT));
      exp_abort = ab;
      if (ab) begin
         if (!w) exp_rdata = 32'h0;
      end else if (w) begin
         if (s) mm[a[12:0]] = d;
         else mm[a[12:0]][7:0] = d[7:0];
      end else begin
         exp_rdata = s ? mm[a[12:0]] : {24'h0, mm[a[12:0]][7:0]};
      end
   endtask

   task automatic drive_idle();
      bus.trans = 2'b00;
      bus.write = 1'b0;
      bus.size  = 1'b1;
      bus.prot  = 2'b00;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
   endtask

   // One transfer: present, count wait states while scrambling the bus, then check outputs
   task automatic xfer(input string tag, input logic [1:0] tr, input logic w, input logic s,
                       input logic priv, input logic [31:0] a, input logic [31:0] d);
      int exp_w;
      int lows;
      exp_w     = (tr == 2'b10) ? N_W : S_W;
      bus.trans = tr;
      bus.write = w;
      bus.size  = s;
      bus.prot  = {priv, 1'($urandom)};
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
      lows = 0;
      while (bus.ready !== 1'b1 && lows < 20) begin
         lows++;
         bus.addr  = 32'h0;
         bus.wdata = $urandom;
         bus.write = 1'($urandom);
         bus.size  = 1'($urandom);
         bus.prot  = 2'($urandom);
         bus.trans = 2'($urandom);
         @(posedge clk);
         #1;
      end
      drive_idle();
      model_xfer(w, s, priv, a, d);
      chk({tag, " wait"}, 32'(lows), 32'(exp_w));
      chk({tag, " rdata"}, bus.rdata, exp_rdata);
      chk({tag, " abort"}, {31'h0, bus.abort}, {31'h0, exp_abort});
   endtask

   logic [31:0] pool [16];
   logic [31:0] held_rdata;
   logic        held_abort;

   initial begin
      pool = '{32'h10, 32'h11, 32'hFF, 32'h100, 32'h101, 32'h300, 32'h301, 32'h302,
               32'h400, 32'h1FFE, 32'h1FFF, 32'h2000, 32'h2001, 32'hFFFF_FFFF, 32'h0, 32'h5};
      exp_rdata = 32'h0;
      exp_abort = 1'b0;
      drive_idle();

      // Reset for two cycles
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset ready", {31'h0, bus.ready}, 32'h1);
      chk("reset rdata", bus.rdata, 32'h0);
      chk("reset abort", {31'h0, bus.abort}, 32'h0);

      // S-cycle zero-wait write then read
      xfer("s_wr", 2'b11, 1'b1, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
      xfer("s_rd", 2'b11, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0);
      chk("s_rd const", bus.rdata, 32'hDEAD_BEEF);

      // N-cycle read with address scrambled during the wait
      xfer("n_rd", 2'b10, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
      chk("n_rd const", bus.rdata, 32'hDEAD_BEEF);

      // Byte write and word/byte readback
      xfer("b_wr", 2'b11, 1'b1, 1'b0, 1'b1, 32'h300, 32'h1234_5678);
      xfer("w_rd", 2'b11, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
      chk("w_rd const", bus.rdata, 32'hDEAD_BE78);
      xfer("b_rd", 2'b10, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
      chk("b_rd const", bus.rdata, 32'h0000_0078);

      // Protection and range aborts
      xfer("p_wr", 2'b11, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5);
      xfer("u_wr", 2'b11, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0BAD_0BAD);
      chk("u_wr const", {31'h0, bus.abort}, 32'h1);
      xfer("u_rd", 2'b11, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      chk("u_rd const", bus.rdata, 32'hA5A5_A5A5);
      xfer("p_wr2", 2'b10, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0000_005A);
      xfer("u_wr255", 2'b11, 1'b1, 1'b1, 1'b0, 32'hFF, 32'h1);
      xfer("u_wr256", 2'b11, 1'b1, 1'b1, 1'b0, 32'h100, 32'h2);
      xfer("oor_rd", 2'b11, 1'b0, 1'b1, 1'b1, 32'd8192, 32'h0);
      chk("oor_rd const", bus.rdata, 32'h0);
      xfer("max_rd", 2'b10, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
      xfer("top_wr", 2'b11, 1'b1, 1'b1, 1'b0, 32'd8191, 32'h7777_8888);
      xfer("top_rd", 2'b11, 1'b0, 1'b1, 1'b0, 32'd8191, 32'h0);

      // Reset during the first wait cycle discards the pending write
      xfer("pre400", 2'b11, 1'b1, 1'b1, 1'b1, 32'h400, 32'h1122_3344);
      bus.trans = 2'b10;
      bus.write = 1'b1;
      bus.size  = 1'b1;
      bus.prot  = 2'b11;
      bus.addr  = 32'h400;
      bus.wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      chk("mid ready low", {31'h0, bus.ready}, 32'h0);
      drive_idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_rdata = 32'h0;
      exp_abort = 1'b0;
      chk("mid ready", {31'h0, bus.ready}, 32'h1);
      chk("mid abort", {31'h0, bus.abort}, 32'h0);
      xfer("post400", 2'b11, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
      chk("post400 const", bus.rdata, 32'h1122_3344);

      // Transfer presented together with reset is not accepted
      xfer("pre305", 2'b11, 1'b1, 1'b1, 1'b1, 32'h305, 32'h0000_1111);
      bus.trans = 2'b11;
      bus.write = 1'b1;
      bus.size  = 1'b1;
      bus.prot  = 2'b11;
      bus.addr  = 32'h305;
      bus.wdata = 32'hBAD0_BAD0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive_idle();
      exp_rdata = 32'h0;
      exp_abort = 1'b0;
      xfer("post305", 2'b11, 1'b0, 1'b1, 1'b0, 32'h305, 32'h0);

      // Random traffic over a boundary-heavy address pool
      foreach (pool[i]) begin
         if (pool[i] < ADDR_WORDS) xfer("init", 2'b11, 1'b1, 1'b1, 1'b1, pool[i], $urandom);
      end
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            held_rdata = bus.rdata;
            held_abort = bus.abort;
            bus.trans  = {1'b0, 1'($urandom)};
            bus.addr   = pool[$urandom_range(0, 15)];
            bus.write  = 1'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            drive_idle();
            chk("idle ready", {31'h0, bus.ready}, 32'h1);
            chk("idle rdata", bus.rdata, exp_rdata);
            chk("idle abort", {31'h0, bus.abort}, {31'h0, exp_abort});
         end else begin
            xfer("rnd", {1'b1, 1'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom),
                 pool[$urandom_range(0, 15)], $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/wait_state_memory.md
# wait_state_memory

Memory responder for the processor's memory interface (addr/wdata/rdata/abort/write/size/prot/trans). It decodes N-cycle and S-cycle transfers and inserts a programmable number of wait states per cycle type, signalled through a `ready` output. It generates `abort` for out-of-range addresses and for unprivileged writes to a protected low region. It sits between the processor core and word-addressed backing storage, as the target end of the core's bus.

## Interface
- `ADDR_WORDS`, 8192: number of 32-bit words of storage; valid word addresses are 0..ADDR_WORDS-1.
- `N_WAIT`, 2: wait states inserted for a nonsequential (N) transfer; legal range 0..15.
- `S_WAIT`, 0: wait states inserted for a sequential (S) transfer; legal range 0..15.
- `PROT_LIMIT`, 256: word addresses below this value accept writes only when the transfer is privileged.

- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset. There is one clock.
- `addr` input 32: word address.
- `wdata` input 32: write data.
- `rdata` output 32: read data, registered.
- `abort` output 1: registered abort status of the most recently completed transfer.
- `write` input 1: 1 = write, 0 = read.
- `size` input 1: 1 = word, 0 = byte (low byte lane).
- `prot` input 2: bit 1 = privileged, bit 0 = data (1) or opcode fetch (0). Bit 0 is informational only.
- `trans` input 2: transfer type. 00 = idle, 01 = coprocessor (no memory access), 10 = N-cycle, 11 = S-cycle.
- `ready` output 1: 1 = responder can accept a transfer this cycle; 0 = wait state in progress.

## Operation
- **States:** IDLE and WAIT. The wait counter `cnt` is 4 bits.
- **Accept:** a transfer is accepted on a rising edge when `ready==1` and `trans[1]==1`. Transfers with `trans` 00 or 01 are never accepted and change no state.
- **Wait count:** W = `N_WAIT` if `trans==10`, W = `S_WAIT` if `trans==11`.
- **Zero-wait accept (W==0):** the access completes on the accept edge. The FSM stays in IDLE and `ready` stays 1.
- **Wait accept (W>0):** on the accept edge, latch `addr`, `wdata`, `write`, `size` and `prot[1]`; set `cnt<=W-1`, `ready<=0`, state WAIT.
- **In WAIT, each edge:**
  - If `cnt==0`: complete the latched access, set `ready<=1`, return to IDLE.
  - Otherwise: `cnt<=cnt-1`.
  - Bus inputs are ignored while in WAIT.
- **Abort condition** (evaluated on the latched or accepted request): `addr >= ADDR_WORDS`, OR (`write` AND NOT `prot[1]` AND `addr < PROT_LIMIT`).
- **Completion, aborted:** `abort<=1`. Storage is unchanged. On a read, `rdata<=0`.
- **Completion, read, not aborted:** `abort<=0`.
  - Word: `rdata<=mem[addr]`.
  - Byte: `rdata<={24'b0, mem[addr][7:0]}`.
- **Completion, write, not aborted:** `abort<=0` and `rdata` holds its previous value.
  - Word: `mem[addr]<=wdata`.
  - Byte: `mem[addr][7:0]<=wdata[7:0]`; bits 31:8 are preserved.
- **Hold behaviour:** `abort` and `rdata` hold their values until the next completion. Idle cycles do not clear them.
- **Address width:** the address compare uses the full 32 bits; there is no wrap-around. Address 0xFFFFFFFF aborts.
- **Reset:**
  - Output values: `ready=1`, `rdata=0`, `abort=0`; state IDLE, `cnt=0`.
  - Storage contents are not reset.
  - Reset has priority over everything else. A pending WAIT transfer is discarded: no write is performed and no abort is reported.
  - A transfer presented in the same cycle as `reset` is not accepted.

## Timing
- **Zero-wait latency:** a transfer accepted at edge E has `rdata`/`abort` valid after edge E.
  - Back-to-back zero-wait transfers sustain one per cycle.
  - The value at edge E+1 reflects the transfer accepted at E+1.
- **Wait latency:** for W>0, `ready` is low for exactly W cycles (after edges E..E+W-1). Completion and `ready` rising occur at edge E+W. The next accept is possible at edge E+W+1.
- **Read-after-write:** a write at edge E followed by a read of the same address at E+1 returns the new data.
- **Parameter switching:** mixed N/S traffic uses the W of each transfer's own `trans` value at its accept edge.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, then release → `ready=1`, `rdata=0`, `abort=0`.
- **S-cycle zero-wait:**
  - Stimulus: S-cycle word write `addr=0x300`, `wdata=0xDEADBEEF`, privileged, then an S-cycle word read of `0x300` on the next cycle.
  - Response: `rdata=0xDEADBEEF` after the second edge, `abort=0`, `ready` never low.
- **N-cycle wait states:**
  - Stimulus: N-cycle read of `0x300` with `N_WAIT=2`; `addr` is changed to `0x0` during the wait cycles.
  - Response: `ready` low for exactly 2 cycles, then `rdata=0xDEADBEEF` (the latched address is used).
- **Byte access:**
  - Stimulus: byte write `wdata=0x12345678` to `0x300`, then a word read.
  - Response: `rdata=0xDEADBE78`. A byte read of the same address returns `0x00000078`.
- **Aborts:**
  - Unprivileged write to `0x10`: `abort=1` and `mem[0x10]` is unchanged. A subsequent privileged write to `0x10` gives `abort=0`.
  - Read of `addr=8192`: `abort=1`, `rdata=0`.
- **Reset mid-wait:**
  - Stimulus: N-cycle write `0xCAFEF00D` to `0x400`; assert `reset` during the first wait cycle.
  - Response: `ready=1` after the reset edge, `abort=0`. A later read of `0x400` returns its old value.
